// File: rtl/mul_seq_16.sv
// Sequential 16x16 unsigned shift-add multiplier, one multiplier bit per clock.
// The per-iteration add is a ripple of four 4-bit carry-lookahead slices.

module cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] pr;
    logic       c1, c2, c3;

    assign g  = x & y;
    assign pr = x ^ y;

    // All slice carries come straight from generate/propagate terms and cin.
    assign c1 = g[0] | (pr[0] & cin);
    assign c2 = g[1] | (pr[1] & g[0]) | (pr[1] & pr[0] & cin);
    assign c3 = g[2] | (pr[2] & g[1]) | (pr[2] & pr[1] & g[0])
              | (pr[2] & pr[1] & pr[0] & cin);
    assign co = g[3] | (pr[3] & g[2]) | (pr[3] & pr[2] & g[1])
              | (pr[3] & pr[2] & pr[1] & g[0])
              | (pr[3] & pr[2] & pr[1] & pr[0] & cin);

    assign s = pr ^ {c3, c2, c1, cin};
endmodule

module mul_seq_16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);
    localparam int SLICES = WIDTH / 4;
    localparam int CW     = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum_lo;
    logic [SLICES:0]  carry;
    logic [WIDTH:0]   sum;

    assign addend   = lo[0] ? mcand : '0;
    assign carry[0] = 1'b0;

    genvar k;
    generate
        for (k = 0; k < SLICES; k++) begin : g_slice
            cla4 u_cla (
                .x   (hi[4*k +: 4]),
                .y   (addend[4*k +: 4]),
                .cin (carry[k]),
                .s   (sum_lo[4*k +: 4]),
                .co  (carry[k+1])
            );
        end
    endgenerate

    // Carry-out becomes bit 16 of the partial sum. After the right shift the
    // upper word's top bit is always zero, so hi is kept at 16 bits.
    assign sum = {carry[SLICES], sum_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        lo    <= b;
                        hi    <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    hi    <= sum[WIDTH:1];
                    lo    <= {sum[0], lo[WIDTH-1:1]};
                    count <= count + 1'b1;
                    // Last iteration: publish the shifted product directly.
                    if (count == CW'(WIDTH - 1)) begin
                        p     <= {sum, lo[WIDTH-1:1]};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/mul_seq_16.md
MUL_SEQ_16 -- requirements
Module: mul_seq_16

Interface
REQ-001 Parameter: WIDTH, 16, operand width; the block SHALL support only 16, with the product 2*WIDTH = 32 bits.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin a multiply; sampled only in IDLE or DONE.
REQ-005 Port: a  input  16  multiplicand, unsigned; captured on the accepting edge.
REQ-006 Port: b  input  16  multiplier, unsigned; captured on the accepting edge.
REQ-007 Port: busy  output  1  high while an operation is in RUN.
REQ-008 Port: done  output  1  one-cycle pulse; p is valid for the new result.
REQ-009 Port: p  output  32  product, registered; holds the last completed result.

Function
REQ-010 The block SHALL be an unsigned shift-add multiplier, one multiplier bit per clock.
REQ-011 The per-iteration add SHALL be 16-bit + 16-bit with carry-out, built as four chained 4-bit carry-lookahead adder slices (carry in of slice 0 = 0, co of slice k feeds cin of slice k+1).
REQ-012 FSM states SHALL be IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-013 IDLE, start=1 SHALL: capture a into the multiplicand register, load the working register lo<=b and hi<=0 (17 bits), clear the iteration counter, go to RUN.
REQ-014 IDLE, start=0 SHALL leave the state IDLE with all registers held.
REQ-015 Each RUN edge SHALL apply sum = hi + (lo[0] ? a : 0) as 17 bits (adder carry-out as MSB), then {hi,lo} <= {sum,lo} >> 1, then counter+1.
REQ-016 The RUN edge that completes iteration 16 (counter==15) SHALL load p <= the final {hi[15:0],lo}, set done=1 and go to DONE.
REQ-017 The block SHALL ignore start while in RUN, with no effect on operands, counter or outputs.
REQ-018 DONE SHALL last exactly one cycle; the next edge SHALL go to IDLE with done=0, or, if start=1, accept new operands per REQ-013 and go to RUN (back-to-back).
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; busy and done SHALL never both be 1.
REQ-020 Latency: for start accepted at edge E0, done SHALL be high from E16 to E17 (16 RUN cycles), and the next accept SHALL be possible at E17.
REQ-021 p SHALL change only at the completing edge (REQ-016) or on reset; it SHALL hold its value through IDLE, RUN and subsequent DONE states.
REQ-022 The result SHALL be exact for all inputs; the maximum is 0xFFFF*0xFFFF = 0xFFFE0001, and no overflow is possible.
REQ-023 The a and b inputs SHALL be don't-care except on the accepting edge.

Reset
REQ-024 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, p=0x00000000, counter=0, hi=0 and lo=0.
REQ-025 rst SHALL take priority over start and over any RUN/DONE transition.
REQ-026 An operation in flight at reset SHALL be discarded, and no done pulse SHALL follow.
REQ-027 In the first cycle after rst deasserts, the block SHALL be in IDLE and able to accept start.

Verification
REQ-028 Basic: a=3, b=5, start pulse at E0 -> busy=1 from E1 through E15; done=1 and p=0x0000000F in the E16-E17 cycle; busy=0 then.
REQ-029 Corners: 0xFFFF*0xFFFF -> p=0xFFFE0001; 0x1234*0 -> p=0; 0x8000*0x0002 -> p=0x00010000; 1*0xABCD -> p=0x0000ABCD.
REQ-030 Start during busy: accept 2*7, then pulse start with a=9 and b=9 at E5 -> result p=0x0000000E at E16; no extra done pulse.
REQ-031 Back-to-back: start=1 held through the DONE cycle with new operands 0x0100*0x0100 -> the first result is seen, then done at E33 with p=0x00010000; p=first result in between.
REQ-032 Reset mid-operation: rst=1 at E8 of a run -> busy=0, done=0, p=0 next cycle, no done pulse afterward; a new start after release gives the correct result.
REQ-033 Random: 10k random (a,b) pairs with random start gaps -> every done shows p == a*b, with exactly one done per accepted start.
